// File: rtl/music_pkg.sv
// ---------------------------------------------------------------------------
// music_pkg : widths, ROM entry layout and sequencer states for song_reader
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package music_pkg;

  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int ROM_DATA_W = 12;

  // A zero duration marks the end of a song in the ROM.
  localparam logic [DUR_W-1:0] DUR_TERMINATOR = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DATA      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_GUARD     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_END       = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/song_reader_if.sv
// ---------------------------------------------------------------------------
// song_reader_if : control, song ROM and note-load signals of song_reader
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface song_reader_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
);
  import music_pkg::*;

  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          note_done;
  logic [ROM_DATA_W-1:0]         rom_data;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          new_note;
  logic                          song_done;
  logic                          busy;

  modport master (
    input  play, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done, busy
  );

  modport slave (
    output play, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done, busy
  );

endinterface

`default_nettype wire

// File: rtl/note_index_counter.sv
// ---------------------------------------------------------------------------
// note_index_counter : saturating note index with sync clear and at_max flag
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module note_index_counter #(
  parameter int IDX_BITS = 5
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                clear,
  input  wire logic                enable,
  output logic      [IDX_BITS-1:0] count,
  output logic                     at_max
);

  assign at_max = (count == {IDX_BITS{1'b1}});

  // Never wraps: the last entry of a song must lead to END, not entry 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/song_reader.sv
// ---------------------------------------------------------------------------
// song_reader : walks a song in an external sync ROM and feeds note_player
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module song_reader
  import music_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
) (
  input wire logic      clk,
  input wire logic      reset,
  song_reader_if.master bus
);

  state_t               state;
  state_t               state_nxt;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  idx;
  logic                 idx_at_max;
  logic                 idx_clear;
  logic                 idx_inc;
  logic                 capture;
  logic                 song_change;
  logic [NOTE_W-1:0]    note_q;
  logic [DUR_W-1:0]     dur_q;
  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  assign rom_note = bus.rom_data[ROM_DATA_W-1 -: NOTE_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];

  // A new song select aborts the current song from any active state but END.
  assign song_change = (state != ST_IDLE) && (state != ST_END) && (bus.song != song_q);

  note_index_counter #(
    .IDX_BITS (IDX_BITS)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clear  (idx_clear),
    .enable (idx_inc),
    .count  (idx),
    .at_max (idx_at_max)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      song_q <= '0;
      note_q <= '0;
      dur_q  <= '0;
    end else begin
      state <= state_nxt;
      if (idx_clear) begin
        song_q <= bus.song;
      end
      if (capture) begin
        note_q <= rom_note;
        dur_q  <= rom_dur;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_clear = 1'b0;
    idx_inc   = 1'b0;
    capture   = 1'b0;
    if (song_change) begin
      state_nxt = ST_FETCH;
      idx_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.play) begin
            state_nxt = ST_FETCH;
            idx_clear = 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.play) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (bus.play) begin
            if (rom_dur == DUR_TERMINATOR) begin
              state_nxt = ST_END;
            end else begin
              capture   = 1'b1;
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (bus.play) state_nxt = ST_GUARD;
        end
        // Masks a done still asserted from the previous note.
        ST_GUARD: state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (bus.note_done) begin
            if (idx_at_max) begin
              state_nxt = ST_END;
            end else begin
              idx_inc   = 1'b1;
              state_nxt = ST_FETCH;
            end
          end
        end
        ST_END:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = {song_q, idx};
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.new_note  = (state == ST_LOAD) && bus.play && !song_change;
  assign bus.song_done = (state == ST_END);
  assign bus.busy      = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/song_reader.md
# song_reader

Sequencer that sits upstream of `note_player` and drives the opposite side of its note-load handshake. It walks a song stored in an external synchronous song ROM, presents each note/duration pair with a one-cycle `new_note` pulse, then waits for `note_done` before fetching the next entry. It reports end of song and supports pause and mid-song song change.

## Interface
Parameters:
- SONG_BITS, 2, song select width (4 songs)
- IDX_BITS, 5, note index width (32 entries per song)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- play  in  1  level; 1 = advance, 0 = pause
- song  in  SONG_BITS  song select
- note_done  in  1  from `note_player` done_with_note
- rom_data  in  12  {note[11:6], duration[5:0]}, valid one cycle after rom_addr
- rom_addr  out  SONG_BITS+IDX_BITS  registered {song_q, idx}
- note  out  6  note_to_load for `note_player`
- duration  out  6  duration_to_load for `note_player`
- new_note  out  1  load_new_note pulse
- song_done  out  1  one-cycle end-of-song pulse
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, FETCH, DATA, LOAD, GUARD, WAIT_DONE, END.
- IDLE: when play=1, latch song_q<=song, set idx<=0, go to FETCH.
- FETCH: rom_addr = {song_q, idx}. Go to DATA.
- DATA: rom_data valid.
  - If duration field == 0, the entry is a terminator: go to END. note and duration are not updated.
  - Otherwise capture note and duration, go to LOAD.
- LOAD: new_note=1 for exactly this cycle. Go to GUARD.
- GUARD: one cycle in which note_done is ignored, so a stale done from the previous note is not counted. Go to WAIT_DONE.
- WAIT_DONE: on note_done=1:
  - If idx == 2^IDX_BITS-1, go to END.
  - Otherwise idx<=idx+1 and go to FETCH.
- END: song_done=1 for this cycle, then IDLE.
- Pause: play=0 freezes the FSM in FETCH, DATA and LOAD.
  - While paused in LOAD, new_note is held 0. The pulse is issued on the first play=1 cycle.
  - WAIT_DONE and GUARD still advance while paused, because the note in flight must complete.
  - rom_addr is held, so DATA re-samples the same entry after a pause.
- Song change: if song != song_q while busy and the state is not END:
  - Abort to FETCH with song_q<=song and idx<=0.
  - No song_done is issued.
  - Takes priority over every other transition in the same cycle.
- Wrap: idx never wraps. The final entry of a song always leads to END.
- note and duration hold their last loaded values until the next DATA capture.

## Timing
- Reset (reset=0 at a clk edge): state IDLE, rom_addr 0, note 0, duration 0, new_note 0, song_done 0, busy 0, idx 0, song_q 0.
- Start latency: play=1 sampled in IDLE at edge T:
  - FETCH during T+1
  - DATA during T+2
  - new_note high during T+3, with note/duration already stable that cycle
- Inter-note latency: note_done sampled at edge D in WAIT_DONE gives new_note high during D+3.
- Terminator: DATA at cycle N gives song_done high during N+1 and IDLE at N+2.
- Simultaneous events:
  - reset=0 overrides everything.
  - Song change overrides note_done.
  - note_done in GUARD is dropped.
- reset=0 mid-note: all outputs return to reset values at the next edge. The downstream `note_player` is reset by the same signal.

## Structure
- Shared package `music_pkg`:
  - NOTE_W=6, DUR_W=6, ROM_DATA_W=12
  - FSM state enum/localparams
  - DUR_TERMINATOR=6'd0
- One natural sub-module: `note_index_counter`.
  - IDX_BITS-wide counter with synchronous clear, enable and `at_max` flag.
  - Uses the same active-low synchronous reset.
- The ROM is external, so the bench owns song contents.

## Test plan
- Reset hold: reset=0 for 4 cycles → all outputs 0, busy=0. Release with play=0 → stays IDLE.
- Single note: song=1, ROM[{1,0}]={6'd10,6'd2}, ROM[{1,1}] duration 0; play=1 at T → rom_addr=7'h20 at T+1, new_note=1 with note=10 and duration=2 at T+3. Then note_done=1 → song_done at D+3, busy=0 at D+4.
- Stale done: hold note_done=1 continuously from T+3 → exactly one new_note per entry, and the GUARD cycle ignores done.
- Pause: play=0 during DATA of entry 2 for 5 cycles → no new_note and rom_addr unchanged. Resume → new_note two cycles later with the correct data.
- Song change: switch song 1→3 during WAIT_DONE of entry 4 → rom_addr={3,0} next cycle, no song_done, first note of song 3 loaded 3 cycles later.
- Full song: all 32 entries with nonzero duration → 32 new_note pulses, song_done after the 32nd note_done, no address wrap.
